// File: rtl/packet_seq_pkg.sv
// Shared types for the packet sequencer: FSM states, outcome codes, default widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package packet_seq_pkg;

    localparam int WORD_WIDTH_DEF = 16;
    localparam int HOP_WIDTH_DEF  = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DCHK_EN,
        S_DCHK_GO,
        S_DCHK_WAIT,
        S_DECIDE,
        S_NH_EN,
        S_NH_GO,
        S_NH_WAIT,
        S_TX_WAIT,
        S_DELIVER,
        S_DROP,
        S_FIN
    } seq_state_t;

    typedef enum logic [1:0] {
        RES_NONE      = 2'd0,
        RES_DELIVERED = 2'd1,
        RES_FORWARDED = 2'd2,
        RES_DROPPED   = 2'd3
    } result_t;

    typedef enum logic [1:0] {
        DROP_NONE        = 2'd0,
        DROP_HOP_LIMIT   = 2'd1,
        DROP_NO_NEXT_HOP = 2'd2,
        DROP_TIMEOUT     = 2'd3
    } drop_reason_t;

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting and flags expiry on the TIMEOUT-th one.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clear has priority over counting.
module seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic nrst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = count_en && !clear && (count == LAST);

endmodule

// File: rtl/packet_sequencer.sv
// Per-packet controller: destination check, next-hop select, then deliver / forward / drop.
// Latency: start to deliver pulse 5 cycles best case; done pulse one cycle after outcome.
// Backpressure: tx_req held until tx_ack; starts while busy are dropped; watchdog bounds every wait.
module packet_sequencer
    import packet_seq_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int HOP_WIDTH  = HOP_WIDTH_DEF,
    parameter int MAX_HOPS   = 15,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] pkt_dest_id,
    input  logic [HOP_WIDTH-1:0]  pkt_hop_count,
    output logic                  dchk_en,
    output logic                  dchk_start,
    output logic [WORD_WIDTH-1:0] dchk_dest_id,
    input  logic                  dchk_done,
    input  logic                  dchk_iamDest,
    output logic                  nh_en,
    output logic                  nh_start,
    input  logic                  nh_done,
    input  logic                  nh_valid,
    input  logic [WORD_WIDTH-1:0] nh_id,
    output logic                  deliver,
    output logic                  tx_req,
    input  logic                  tx_ack,
    output logic [WORD_WIDTH-1:0] tx_next_hop,
    output logic [HOP_WIDTH-1:0]  tx_hop_count,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            result,
    output logic [1:0]            drop_reason
);

    localparam logic [HOP_WIDTH-1:0] MAX_HOPS_W = HOP_WIDTH'(MAX_HOPS);

    seq_state_t           state;
    logic [HOP_WIDTH-1:0] hop_q;
    logic                 iam_dest_q;
    logic                 in_wait;
    logic                 wd_clear;
    logic                 wd_expired;

    // Address matching lives in the external check unit; the node ID is not needed here.
    logic unused_node_id;
    assign unused_node_id = ^MY_NODE_ID;

    always_comb begin
        in_wait  = (state == S_DCHK_WAIT) || (state == S_NH_WAIT) || (state == S_TX_WAIT);
        wd_clear = !in_wait
                 || ((state == S_DCHK_WAIT) && dchk_done)
                 || ((state == S_NH_WAIT)   && nh_done)
                 || ((state == S_TX_WAIT)   && tx_ack);
    end

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .nrst     (nrst),
        .clear    (wd_clear),
        .count_en (in_wait),
        .expired  (wd_expired)
    );

    // Outputs are registered alongside the state transition so they match the state they decode.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            hop_q        <= '0;
            iam_dest_q   <= 1'b0;
            dchk_en      <= 1'b0;
            dchk_start   <= 1'b0;
            dchk_dest_id <= '0;
            nh_en        <= 1'b0;
            nh_start     <= 1'b0;
            deliver      <= 1'b0;
            tx_req       <= 1'b0;
            tx_next_hop  <= '0;
            tx_hop_count <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= RES_NONE;
            drop_reason  <= DROP_NONE;
        end else begin
            dchk_en    <= 1'b0;
            dchk_start <= 1'b0;
            nh_en      <= 1'b0;
            nh_start   <= 1'b0;
            deliver    <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && start) begin
                        dchk_dest_id <= pkt_dest_id;
                        hop_q        <= pkt_hop_count;
                        result       <= RES_NONE;
                        drop_reason  <= DROP_NONE;
                        dchk_en      <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_DCHK_EN;
                    end
                end
                S_DCHK_EN: begin
                    dchk_start <= 1'b1;
                    state      <= S_DCHK_GO;
                end
                S_DCHK_GO: begin
                    state <= S_DCHK_WAIT;
                end
                S_DCHK_WAIT: begin
                    if (dchk_done) begin
                        iam_dest_q <= dchk_iamDest;
                        state      <= S_DECIDE;
                    end else if (wd_expired) begin
                        result      <= RES_DROPPED;
                        drop_reason <= DROP_TIMEOUT;
                        state       <= S_DROP;
                    end
                end
                S_DECIDE: begin
                    if (iam_dest_q) begin
                        deliver <= 1'b1;
                        result  <= RES_DELIVERED;
                        state   <= S_DELIVER;
                    end else if (hop_q >= MAX_HOPS_W) begin
                        result      <= RES_DROPPED;
                        drop_reason <= DROP_HOP_LIMIT;
                        state       <= S_DROP;
                    end else begin
                        nh_en <= 1'b1;
                        state <= S_NH_EN;
                    end
                end
                S_NH_EN: begin
                    nh_start <= 1'b1;
                    state    <= S_NH_GO;
                end
                S_NH_GO: begin
                    state <= S_NH_WAIT;
                end
                S_NH_WAIT: begin
                    if (nh_done) begin
                        if (nh_valid) begin
                            tx_next_hop  <= nh_id;
                            tx_hop_count <= (hop_q == '1) ? hop_q : hop_q + HOP_WIDTH'(1);
                            tx_req       <= 1'b1;
                            state        <= S_TX_WAIT;
                        end else begin
                            result      <= RES_DROPPED;
                            drop_reason <= DROP_NO_NEXT_HOP;
                            state       <= S_DROP;
                        end
                    end else if (wd_expired) begin
                        result      <= RES_DROPPED;
                        drop_reason <= DROP_TIMEOUT;
                        state       <= S_DROP;
                    end
                end
                S_TX_WAIT: begin
                    if (tx_ack) begin
                        tx_req <= 1'b0;
                        result <= RES_FORWARDED;
                        done   <= 1'b1;
                        state  <= S_FIN;
                    end else if (wd_expired) begin
                        tx_req      <= 1'b0;
                        result      <= RES_DROPPED;
                        drop_reason <= DROP_TIMEOUT;
                        state       <= S_DROP;
                    end
                end
                S_DELIVER: begin
                    done  <= 1'b1;
                    state <= S_FIN;
                end
                S_DROP: begin
                    done  <= 1'b1;
                    state <= S_FIN;
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_sequencer.sv
// Directed bench for packet_sequencer: deliver, forward, hop-limit / no-hop / timeout drops, reset, busy start.
// Latency: checks exact cycle positions of handshake and outcome pulses.
// Backpressure: exercises held tx_req under delayed tx_ack.
module tb_packet_sequencer;

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic        en = 1'b0, start = 1'b0;
    logic [15:0] MY_NODE_ID = 16'h0005;
    logic [15:0] pkt_dest_id = '0;
    logic [7:0]  pkt_hop_count = '0;
    logic        dchk_en, dchk_start;
    logic [15:0] dchk_dest_id;
    logic        dchk_done = 1'b0, dchk_iamDest = 1'b0;
    logic        nh_en, nh_start;
    logic        nh_done = 1'b0, nh_valid = 1'b0;
    logic [15:0] nh_id = '0;
    logic        deliver, tx_req;
    logic        tx_ack = 1'b0;
    logic [15:0] tx_next_hop;
    logic [7:0]  tx_hop_count;
    logic        busy, done;
    logic [1:0]  result, drop_reason;

    int checks = 0;
    int failures = 0;

    packet_sequencer dut (
        .clock(clock), .nrst(nrst), .en(en), .start(start), .MY_NODE_ID(MY_NODE_ID),
        .pkt_dest_id(pkt_dest_id), .pkt_hop_count(pkt_hop_count),
        .dchk_en(dchk_en), .dchk_start(dchk_start), .dchk_dest_id(dchk_dest_id),
        .dchk_done(dchk_done), .dchk_iamDest(dchk_iamDest),
        .nh_en(nh_en), .nh_start(nh_start), .nh_done(nh_done), .nh_valid(nh_valid), .nh_id(nh_id),
        .deliver(deliver), .tx_req(tx_req), .tx_ack(tx_ack), .tx_next_hop(tx_next_hop),
        .tx_hop_count(tx_hop_count), .busy(busy), .done(done), .result(result),
        .drop_reason(drop_reason)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [15:0] dest, input logic [7:0] hop);
        en = 1'b1; pkt_dest_id = dest; pkt_hop_count = hop; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({dchk_en, dchk_start, nh_en, nh_start, deliver, tx_req, busy, done, result, drop_reason} !== 12'h0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h expected 000", {dchk_en, dchk_start, nh_en, nh_start, deliver, tx_req, busy, done, result, drop_reason});
        end
        checks++;
        if ({dchk_dest_id, tx_next_hop, tx_hop_count} !== 40'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {dchk_dest_id, tx_next_hop, tx_hop_count});
        end
        tick(); tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_en_gate();
        en = 1'b0; pkt_dest_id = 16'h0005; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, dchk_en} !== 2'b00) begin
            failures++;
            $display("FAIL en_gate: got busy,dchk_en=%b expected 00", {busy, dchk_en});
        end
    endtask

    task automatic test_deliver();
        launch(16'h0005, 8'd2);
        en = 1'b0;                                   // cycle 1: must not abort the packet
        checks++;
        if ({dchk_en, dchk_start, dchk_dest_id} !== {2'b10, 16'h0005}) begin
            failures++;
            $display("FAIL deliver_c1: got %h expected %h", {dchk_en, dchk_start, dchk_dest_id}, {2'b10, 16'h0005});
        end
        tick();                                      // cycle 2
        checks++;
        if ({dchk_en, dchk_start} !== 2'b01) begin
            failures++;
            $display("FAIL deliver_c2: got %b expected 01", {dchk_en, dchk_start});
        end
        tick();                                      // cycle 3
        dchk_done = 1'b1; dchk_iamDest = 1'b1;
        tick();                                      // cycle 4
        dchk_done = 1'b0; dchk_iamDest = 1'b0;
        checks++;
        if ({deliver, done, busy} !== 3'b001) begin
            failures++;
            $display("FAIL deliver_c4: got %b expected 001", {deliver, done, busy});
        end
        tick();                                      // cycle 5
        checks++;
        if ({deliver, done, tx_req} !== 3'b100) begin
            failures++;
            $display("FAIL deliver_c5: got %b expected 100", {deliver, done, tx_req});
        end
        tick();                                      // cycle 6
        checks++;
        if ({deliver, done, tx_req, result, drop_reason} !== 7'b0100100) begin
            failures++;
            $display("FAIL deliver_c6: got %b expected 0100100", {deliver, done, tx_req, result, drop_reason});
        end
        tick();                                      // cycle 7
        checks++;
        if ({busy, done, result} !== 4'b0001) begin
            failures++;
            $display("FAIL deliver_c7: got %b expected 0001", {busy, done, result});
        end
        en = 1'b1;
    endtask

    task automatic test_forward();
        launch(16'h0009, 8'd3);                      // cycle 1
        tick(); tick();                              // cycle 3
        dchk_done = 1'b1; dchk_iamDest = 1'b0;
        tick();                                      // cycle 4
        dchk_done = 1'b0;
        tick();                                      // cycle 5
        checks++;
        if ({nh_en, nh_start} !== 2'b10) begin
            failures++;
            $display("FAIL fwd_nh_en: got %b expected 10", {nh_en, nh_start});
        end
        tick();                                      // cycle 6
        checks++;
        if ({nh_en, nh_start} !== 2'b01) begin
            failures++;
            $display("FAIL fwd_nh_start: got %b expected 01", {nh_en, nh_start});
        end
        tick();                                      // cycle 7
        nh_done = 1'b1; nh_valid = 1'b1; nh_id = 16'h0002;
        tick();                                      // cycle 8
        nh_done = 1'b0; nh_valid = 1'b0; nh_id = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tx_req, done, tx_next_hop, tx_hop_count} !== {2'b10, 16'h0002, 8'd4}) begin
                failures++;
                $display("FAIL fwd_hold%0d: got %h expected %h", i, {tx_req, done, tx_next_hop, tx_hop_count}, {2'b10, 16'h0002, 8'd4});
            end
            if (i < 3) tick();
        end
        tx_ack = 1'b1;
        tick();                                      // cycle 12
        tx_ack = 1'b0;
        checks++;
        if ({tx_req, done, result, drop_reason} !== 6'b011000) begin
            failures++;
            $display("FAIL fwd_fin: got %b expected 011000", {tx_req, done, result, drop_reason});
        end
        tick();
    endtask

    task automatic test_hop_limit();
        int n = 0;
        logic seen_nh = 1'b0;
        launch(16'h0009, 8'd15);
        tick(); tick();
        dchk_done = 1'b1; dchk_iamDest = 1'b0;
        tick();
        dchk_done = 1'b0;
        while (!done && n < 12) begin
            if (nh_en || nh_start) seen_nh = 1'b1;
            tick();
            n++;
        end
        checks++;
        if ({done, seen_nh, result, drop_reason} !== 6'b101101) begin
            failures++;
            $display("FAIL hop_limit: got done,nh,res,reason=%b expected 101101", {done, seen_nh, result, drop_reason});
        end
        tick();
    endtask

    task automatic test_no_next_hop();
        int n = 0;
        launch(16'h0009, 8'd14);                     // one below the limit still asks for a hop
        tick(); tick();
        dchk_done = 1'b1; dchk_iamDest = 1'b0;
        tick();
        dchk_done = 1'b0;
        while (!nh_start && n < 12) begin tick(); n++; end
        checks++;
        if (nh_start !== 1'b1) begin
            failures++;
            $display("FAIL nohop_start: got nh_start=%b expected 1", nh_start);
        end
        tick();
        nh_done = 1'b1; nh_valid = 1'b0;
        tick();
        nh_done = 1'b0;
        n = 0;
        while (!done && n < 12) begin tick(); n++; end
        checks++;
        if ({done, tx_req, result, drop_reason} !== 6'b101110) begin
            failures++;
            $display("FAIL nohop: got done,tx,res,reason=%b expected 101110", {done, tx_req, result, drop_reason});
        end
        tick();
    endtask

    task automatic test_timeout();
        launch(16'h0009, 8'd1);                      // cycle 1
        repeat (256) tick();                         // cycle 257: last wait cycle
        checks++;
        if ({busy, result, drop_reason} !== 5'b10000) begin
            failures++;
            $display("FAIL timeout_early: got %b expected 10000", {busy, result, drop_reason});
        end
        tick();                                      // cycle 258
        checks++;
        if ({result, drop_reason} !== 4'b1111) begin
            failures++;
            $display("FAIL timeout_drop: got %b expected 1111", {result, drop_reason});
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL timeout_done: got %b expected 1", done);
        end
        tick();
    endtask

    task automatic test_timeout_race();
        launch(16'h0005, 8'd1);                      // cycle 1
        repeat (256) tick();                         // cycle 257: done arrives as watchdog expires
        dchk_done = 1'b1; dchk_iamDest = 1'b1;
        tick();
        dchk_done = 1'b0; dchk_iamDest = 1'b0;
        tick();
        checks++;
        if ({deliver, result, drop_reason} !== 5'b10100) begin
            failures++;
            $display("FAIL race: got %b expected 10100", {deliver, result, drop_reason});
        end
        tick(); tick();
    endtask

    task automatic test_busy_start();
        int dones = 0;
        int dchk_pulses = 0;
        launch(16'h0005, 8'd0);                      // cycle 1
        tick();                                      // cycle 2
        start = 1'b1;
        tick();                                      // cycle 3
        start = 1'b0;
        dchk_done = 1'b1; dchk_iamDest = 1'b1;
        tick();
        dchk_done = 1'b0; dchk_iamDest = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            if (dchk_en) dchk_pulses++;
            tick();
        end
        checks++;
        if (dones !== 1 || dchk_pulses !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start: got dones=%0d dchk_en=%0d busy=%b expected 1 0 0", dones, dchk_pulses, busy);
        end
    endtask

    task automatic test_reset_tx();
        int n = 0;
        launch(16'h0009, 8'd6);
        tick(); tick();
        dchk_done = 1'b1; dchk_iamDest = 1'b0;
        tick();
        dchk_done = 1'b0;
        while (!nh_start && n < 12) begin tick(); n++; end
        tick();
        nh_done = 1'b1; nh_valid = 1'b1; nh_id = 16'h00AB;
        tick();
        nh_done = 1'b0; nh_valid = 1'b0;
        checks++;
        if ({tx_req, tx_hop_count} !== {1'b1, 8'd7}) begin
            failures++;
            $display("FAIL rst_tx_pre: got %h expected %h", {tx_req, tx_hop_count}, {1'b1, 8'd7});
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({tx_req, busy, done, result, drop_reason, tx_next_hop, tx_hop_count} !== 31'h0) begin
            failures++;
            $display("FAIL rst_tx: got %h expected 0", {tx_req, busy, done, result, drop_reason, tx_next_hop, tx_hop_count});
        end
        tick();
        nrst = 1'b1;
        tick();
        checks++;
        if ({busy, tx_req} !== 2'b00) begin
            failures++;
            $display("FAIL rst_tx_after: got %b expected 00", {busy, tx_req});
        end
    endtask

    initial begin
        test_reset();
        test_en_gate();
        test_deliver();
        test_forward();
        test_hop_limit();
        test_no_next_hop();
        test_timeout();
        test_timeout_race();
        test_busy_start();
        test_reset_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/packet_sequencer.md
# packet_sequencer

Per-node packet-handling controller for the EER-RL-HM routing datapath. On each received packet it sequences the destination-check unit and the Q-value next-hop selector through their en/start/done handshakes. It then issues exactly one outcome: local delivery, forward to the transmit stage with an incremented hop count, or drop. A watchdog guarantees the controller never hangs on a silent sub-block.

## Interface
- WORD_WIDTH, 16, width of node IDs
- HOP_WIDTH, 8, width of hop count
- MAX_HOPS, 15, hop count at or above which a non-destined packet is dropped
- TIMEOUT, 255, max cycles spent waiting for any done/ack before dropping
- clock  in  1  single system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- en  in  1  block enable; start ignored while low
- start  in  1  one-cycle pulse: packet fields valid this cycle
- MY_NODE_ID  in  WORD_WIDTH  this node's ID, static
- pkt_dest_id  in  WORD_WIDTH  packet destination ID
- pkt_hop_count  in  HOP_WIDTH  packet hop count
- dchk_en / dchk_start  out  1  destination-check handshake
- dchk_dest_id  out  WORD_WIDTH  latched destination ID to check unit
- dchk_done / dchk_iamDest  in  1  check complete / result
- nh_en / nh_start  out  1  next-hop selector handshake
- nh_done / nh_valid  in  1  selection complete / a usable neighbour exists
- nh_id  in  WORD_WIDTH  selected neighbour
- deliver  out  1  one-cycle pulse: packet is for this node
- tx_req  out  1  forward request, held until tx_ack
- tx_ack  in  1  transmit stage accepted
- tx_next_hop  out  WORD_WIDTH  latched nh_id
- tx_hop_count  out  HOP_WIDTH  latched pkt_hop_count+1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of each packet
- result  out  2  0 none, 1 delivered, 2 forwarded, 3 dropped
- drop_reason  out  2  0 none, 1 hop limit, 2 no next hop, 3 timeout

## Operation
- States: IDLE, DCHK_EN, DCHK_GO, DCHK_WAIT, DECIDE, NH_EN, NH_GO, NH_WAIT, TX_WAIT, DELIVER, DROP, FIN.
- IDLE: if en && start, latch pkt_dest_id and pkt_hop_count, clear result/drop_reason, go to DCHK_EN. Otherwise stay.
- DCHK_EN: dchk_en=1 for this cycle -> DCHK_GO. DCHK_GO: dchk_start=1 -> DCHK_WAIT.
- DCHK_WAIT: on dchk_done, latch dchk_iamDest -> DECIDE.
- DECIDE: if iamDest -> DELIVER. Else if hop_count >= MAX_HOPS -> DROP with reason 1. Else -> NH_EN.
- NH_EN / NH_GO: same as the check unit, with nh_en and nh_start -> NH_WAIT.
- NH_WAIT: on nh_done, if nh_valid, latch nh_id and go to TX_WAIT. Otherwise -> DROP with reason 2.
- TX_WAIT: tx_req=1. On tx_ack, set result=2 -> FIN.
- DELIVER: deliver=1, result=1 -> FIN.
- DROP: result=3 -> FIN.
- FIN: done=1 -> IDLE.
- Watchdog: cycle counter cleared on entering DCHK_WAIT, NH_WAIT or TX_WAIT; increments each cycle in those states. If it reaches TIMEOUT before done/ack -> DROP with reason 3.
- tx_hop_count = latched hop_count+1, saturating at all-ones. The saturated value is unreachable when MAX_HOPS < 2^HOP_WIDTH-1.
- en deasserted mid-packet does not abort the current packet; it only gates new starts.

## Timing
- All outputs are registered and decoded from the current state.
- Reset (async, any state): state=IDLE; every output 0, including result, drop_reason, tx_next_hop and tx_hop_count; watchdog 0.
- start at edge 0 -> dchk_en high in cycle 1, dchk_start high in cycle 2.
- dchk_done sampled from cycle 3. Done seen at edge k -> DECIDE in cycle k+1.
- Best-case deliver: done first sampled at edge 3 -> deliver in cycle 5, done pulse in cycle 6, IDLE in cycle 7.
- start during busy is ignored, not queued.
- Done/ack in the same cycle the watchdog expires: done/ack wins.
- result and drop_reason hold until the next accepted start.
- tx_next_hop and tx_hop_count are stable for the whole tx_req assertion.

## Structure
- Package packet_seq_pkg holds:
  - state enum
  - result codes (NONE/DELIVERED/FORWARDED/DROPPED)
  - drop-reason codes
  - default WORD_WIDTH and HOP_WIDTH
- One sub-module: seq_watchdog, a TIMEOUT-bounded counter with clear, count-enable and expired outputs.

## Test plan
- MY_NODE_ID=0x0005, dest=0x0005, dchk_done at cycle 3 with iamDest=1 -> deliver in cycle 5, done in cycle 6, result=1, tx_req never asserted.
- dest=0x0009, hop=3, nh_valid=1, nh_id=0x0002, tx_ack after 4 cycles -> tx_req held until ack, tx_next_hop=0x0002, tx_hop_count=4, result=2.
- dest=0x0009, hop=15 -> no nh_en pulse, result=3, drop_reason=1.
- nh_done with nh_valid=0 -> result=3, drop_reason=2. dchk_done never asserted, TIMEOUT=255 -> drop_reason=3 after 255 wait cycles.
- nrst low during TX_WAIT -> all outputs 0 immediately. Second start pulsed while busy -> ignored, exactly one done pulse.
